// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock through a ripple chain, LSB digit first.
// Optional signed-overflow output enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.

module full_adder_gate (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   op_a_reg;
    logic [WIDTH-1:0]   op_b_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [DIGIT:0]     chain_c;
    logic [DIGIT-1:0]   digit_sum;
    logic [WIDTH-1:0]   acc_next;
    logic               last_digit;

    // Ripple chain over the current low digit of the operand shift registers.
    assign chain_c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_chain
            full_adder_gate u_fa (
                .a  (op_a_reg[gi]),
                .b  (op_b_reg[gi]),
                .ci (chain_c[gi]),
                .s  (digit_sum[gi]),
                .co (chain_c[gi+1])
            );
        end
    endgenerate

    // op_a doubles as the result accumulator: consumed digits shift out the bottom
    // while result digits enter at the top, so after NUM_DIGITS shifts it holds the sum.
    assign acc_next   = (op_a_reg >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    assign last_digit = (cnt_reg == CNT_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (state_reg == IDLE && in_valid) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
            op_a_reg  <= a;
            op_b_reg  <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            cnt_reg   <= '0;
        end else if (state_reg == BUSY) begin
            op_a_reg  <= acc_next;
            op_b_reg  <= op_b_reg >> DIGIT;
            carry_reg <= chain_c[DIGIT];
            cnt_reg   <= cnt_reg + 1'b1;
            if (last_digit) begin
                sum  <= acc_next;
                cout <= chain_c[DIGIT];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                ovf  <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: three instances (DIGIT=4,16,1) against an arithmetic model.
// Define DIGIT_SERIAL_ADDER_OVF_EN to also check the overflow output.

module tb_digit_serial_adder;
    localparam int W = 16;
    localparam int N = 3;
    localparam int DIG [N] = '{4, 16, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          cin, sub, out_ready;
    logic          iv [N];
    logic          ir [N];
    logic          ov [N];
    logic          co [N];
    logic [W-1:0]  sm [N];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic          of [N];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            digit_serial_adder #(.WIDTH(W), .DIGIT(DIG[gi])) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv[gi]),
                .in_ready  (ir[gi]),
                .a         (a),
                .b         (b),
                .cin       (cin),
                .sub       (sub),
                .out_valid (ov[gi]),
                .out_ready (out_ready),
                .sum       (sm[gi]),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                .ovf       (of[gi]),
`endif
                .cout      (co[gi])
            );
        end
    endgenerate

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic xc, input logic xs);
        int ua, ub, sa, sb, r, sr;
        logic c, o;
        logic [W-1:0] s;
        ua = xa; ub = xb;
        sa = $signed(xa); sb = $signed(xb);
        if (!xs) begin
            r  = ua + ub + int'(xc);
            sr = sa + sb + int'(xc);
            c  = (r > 65535);
        end else begin
            r  = ua - ub - int'(xc);
            sr = sa - sb - int'(xc);
            c  = (r >= 0);
        end
        s = r[W-1:0];
        o = (sr > 32767) || (sr < -32768);
        return {o, c, s};
    endfunction

    task automatic run_op(input int k, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic xs, input string name);
        logic [W+1:0] e;
        int lat;
        e = model(xa, xb, xc, xs);
        out_ready = 1'b1;
        a = xa; b = xb; cin = xc; sub = xs; iv[k] = 1'b1;
        checks++;
        if (ir[k] !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b expected 1", name, ir[k]);
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ov[k] !== 1'b1 && lat < 100);
        checks++;
        if (lat != W / DIG[k]) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, W / DIG[k]);
        end
        checks++;
        if (sm[k] !== e[W-1:0]) begin
            errors++; $display("FAIL %s sum: got %h expected %h", name, sm[k], e[W-1:0]);
        end
        checks++;
        if (co[k] !== e[W]) begin
            errors++; $display("FAIL %s cout: got %b expected %b", name, co[k], e[W]);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        checks++;
        if (of[k] !== e[W+1]) begin
            errors++; $display("FAIL %s ovf: got %b expected %b", name, of[k], e[W+1]);
        end
`endif
        $display("op %s dig=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d",
                 name, DIG[k], xa, xb, xc, xs, sm[k], co[k], lat);
        @(posedge clk); #1;
        checks++;
        if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
            errors++; $display("FAIL %s post-handshake: got ov=%b ir=%b expected ov=0 ir=1", name, ov[k], ir[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) iv[k] = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || sm[k] !== '0 || co[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dig=%0d: got ir=%b ov=%b sum=%h cout=%b expected 1 0 0000 0",
                         DIG[k], ir[k], ov[k], sm[k], co[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_directed();
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_carry_chain");
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
        run_op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, "sub_bin");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_add");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "ovf_sub");
    endtask

    task automatic test_backpressure();
        logic [W+1:0] e;
        int wait_cnt;
        e = model(16'hA5C3, 16'h1F0E, 1'b1, 1'b0);
        out_ready = 1'b0;
        a = 16'hA5C3; b = 16'h1F0E; cin = 1'b1; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        wait_cnt = 0;
        while (ov[0] !== 1'b1 && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'($urandom); a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sm[0] !== e[W-1:0] || co[0] !== e[W]) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got ov=%b ir=%b sum=%h cout=%b expected 1 0 %h %b",
                         i, ov[0], ir[0], sm[0], co[0], e[W-1:0], e[W]);
            end
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || sm[0] !== e[W-1:0]) begin
            errors++;
            $display("FAIL backpressure release: got ov=%b ir=%b sum=%h expected 0 1 %h",
                     ov[0], ir[0], sm[0], e[W-1:0]);
        end
        $display("backpressure held 10 cycles sum=%h cout=%b", sm[0], co[0]);
    endtask

    task automatic test_reset_abort();
        a = W'($urandom); b = W'($urandom); cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || sm[0] !== '0 || co[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got ov=%b ir=%b sum=%h cout=%b expected 0 1 0000 0",
                     ov[0], ir[0], sm[0], co[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ov[0] !== 1'b0) begin
                errors++; $display("FAIL reset_abort pulse: got out_valid=%b expected 0", ov[0]);
            end
        end
        $display("reset abort done");
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_digit_variants();
        run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, "dig16_basic");
        run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, "dig1_basic");
    endtask

    task automatic test_random();
        for (int i = 0; i < 45; i++) begin
            run_op(i % N, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_digit_variants();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
